// File: rtl/debounced_event_counter.sv
// debounced_event_counter: debounced up/down press counter with step, limit and wrap/saturate
//   clock, reset (sync, active-high), button/button_down (raw async),
//   clear (sync clear), enable (gate events) -> counter, at_max, at_zero, limit_pulse
module debounce_ch #(
  parameter int DEBOUNCE = 4
) (
  input  logic clock,
  input  logic reset,
  input  logic raw,
  output logic press
);
  localparam int TW = $clog2(DEBOUNCE + 1);
  typedef enum logic {STABLE, PENDING} state_t;
  state_t state, state_n;
  logic [1:0] sync;
  logic level, level_n, level_q, mismatch, done;
  logic [TW-1:0] timer, timer_n, count;
  always_ff @(posedge clock) begin
    if (reset) begin
      sync <= '0;
      state <= STABLE;
      level <= 1'b0;
      level_q <= 1'b0;
      timer <= '0;
    end else begin
      sync <= {sync[0], raw};
      state <= state_n;
      level <= level_n;
      level_q <= level;
      timer <= timer_n;
    end
  end
  // count = consecutive mismatching samples including the current one
  always_comb begin
    mismatch = sync[1] != level;
    count = (state == PENDING ? timer : '0) + TW'(1);
    done = mismatch && count == TW'(DEBOUNCE);
    state_n = mismatch && !done ? PENDING : STABLE;
    timer_n = mismatch && !done ? count : '0;
    level_n = done ? ~level : level;
  end
  assign press = level & ~level_q;
endmodule

module debounced_event_counter #(
  parameter int WIDTH     = 8,
  parameter int MAX_COUNT = 255,
  parameter int STEP      = 1,
  parameter int DEBOUNCE  = 4,
  parameter int WRAP_MODE = 1
) (
  input  logic             clock,
  input  logic             reset,
  input  logic             button,
  input  logic             button_down,
  input  logic             clear,
  input  logic             enable,
  output logic [WIDTH-1:0] counter,
  output logic             at_max,
  output logic             at_zero,
  output logic             limit_pulse
);
  localparam logic [WIDTH:0] max_c = (WIDTH+1)'(MAX_COUNT);
  localparam logic [WIDTH:0] max_p1 = (WIDTH+1)'(MAX_COUNT + 1);
  localparam logic [WIDTH:0] step_c = (WIDTH+1)'(STEP);
  logic up_ev, dn_ev, up_only, dn_only, up_ovf, dn_unf, lim_n;
  logic [WIDTH:0] c;
  logic [WIDTH-1:0] up_val, dn_val, nxt;
  debounce_ch #(.DEBOUNCE(DEBOUNCE)) u_up (.clock(clock), .reset(reset), .raw(button), .press(up_ev));
  debounce_ch #(.DEBOUNCE(DEBOUNCE)) u_dn (.clock(clock), .reset(reset), .raw(button_down), .press(dn_ev));
  // arithmetic runs one bit wider so c + STEP and c + MAX_COUNT + 1 never overflow
  always_comb begin
    c = {1'b0, counter};
    up_only = enable & up_ev & ~dn_ev;
    dn_only = enable & dn_ev & ~up_ev;
    up_ovf = c > max_c - step_c;
    dn_unf = c < step_c;
    up_val = up_ovf ? (WRAP_MODE != 0 ? WIDTH'(c + step_c - max_p1) : WIDTH'(MAX_COUNT)) : WIDTH'(c + step_c);
    dn_val = dn_unf ? (WRAP_MODE != 0 ? WIDTH'(c + max_p1 - step_c) : '0) : WIDTH'(c - step_c);
    nxt = up_only ? up_val : dn_only ? dn_val : counter;
    lim_n = (up_only & up_ovf) | (dn_only & dn_unf);
  end
  always_ff @(posedge clock) begin
    if (reset || clear) begin
      counter <= '0;
      limit_pulse <= 1'b0;
    end else begin
      counter <= nxt;
      limit_pulse <= lim_n;
    end
  end
  assign at_max = counter == WIDTH'(MAX_COUNT);
  assign at_zero = counter == '0;
endmodule

// File: tb/tb_debounced_event_counter.sv
// tb_debounced_event_counter: directed checks of a wrapping default counter and a saturating step-3 counter
module tb_debounced_event_counter;
  logic clk = 1'b0;
  logic reset = 1'b1, button = 1'b0, button_down = 1'b0, clear = 1'b0, enable = 1'b1;
  logic [7:0] counter_a, counter_b;
  logic max_a, max_b, zero_a, zero_b, lim_a, lim_b;
  int checks = 0, passed = 0, ca = 0, cb = 0;
  always #5 clk = ~clk;
  debounced_event_counter dut_a (
    .clock(clk), .reset(reset), .button(button), .button_down(button_down), .clear(clear),
    .enable(enable), .counter(counter_a), .at_max(max_a), .at_zero(zero_a), .limit_pulse(lim_a)
  );
  debounced_event_counter #(.MAX_COUNT(10), .STEP(3), .WRAP_MODE(0)) dut_b (
    .clock(clk), .reset(reset), .button(button), .button_down(button_down), .clear(clear),
    .enable(enable), .counter(counter_b), .at_max(max_b), .at_zero(zero_b), .limit_pulse(lim_b)
  );
  task automatic step(input int n);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask
  task automatic chk(input string tag, input int got, input int exp);
    checks++;
    assert (got === exp) passed++;
    else $error("FAIL %s got %0d expected %0d", tag, got, exp);
  endtask
  task automatic press(input logic u, input logic d, input int ea, input int la, input int eb, input int lb);
    button = u;
    button_down = d;
    step(6);
    chk("hold_a", counter_a, ca);
    chk("hold_b", counter_b, cb);
    step(1);
    chk("cnt_a", counter_a, ea);
    chk("lim_a", lim_a, la);
    chk("cnt_b", counter_b, eb);
    chk("lim_b", lim_b, lb);
    step(1);
    chk("lim_a_off", lim_a, 0);
    chk("lim_b_off", lim_b, 0);
    ca = ea;
    cb = eb;
    button = 1'b0;
    button_down = 1'b0;
    step(12);
    chk("rel_a", counter_a, ca);
    chk("rel_b", counter_b, cb);
  endtask
  initial begin
    step(3);
    chk("rst_cnt_a", counter_a, 0);
    chk("rst_zero_a", zero_a, 1);
    chk("rst_max_a", max_a, 0);
    chk("rst_lim_a", lim_a, 0);
    chk("rst_cnt_b", counter_b, 0);
    reset = 1'b0;
    step(2);
    press(1, 0, 1, 0, 3, 0);
    press(1, 0, 2, 0, 6, 0);
    press(1, 0, 3, 0, 9, 0);
    press(1, 0, 4, 0, 10, 1);
    chk("max_b", max_b, 1);
    press(1, 0, 5, 0, 10, 1);
    for (int i = 0; i < 3; i++) begin
      button = 1'b1;
      step(2);
      button = 1'b0;
      step(2);
    end
    chk("bounce_a", counter_a, 5);
    chk("bounce_b", counter_b, 10);
    press(1, 0, 6, 0, 10, 1);
    press(0, 1, 5, 0, 7, 0);
    press(1, 1, 5, 0, 7, 0);
    clear = 1'b1;
    step(1);
    clear = 1'b0;
    chk("clr_a", counter_a, 0);
    chk("clr_b", counter_b, 0);
    ca = 0;
    cb = 0;
    press(0, 1, 255, 1, 0, 1);
    chk("max_a", max_a, 1);
    chk("zero_b", zero_b, 1);
    press(1, 0, 0, 1, 3, 0);
    chk("zero_a", zero_a, 1);
    press(1, 0, 1, 0, 6, 0);
    button = 1'b1;
    step(6);
    clear = 1'b1;
    step(1);
    clear = 1'b0;
    chk("clr_ev_a", counter_a, 0);
    chk("clr_ev_b", counter_b, 0);
    chk("clr_ev_lim", lim_b, 0);
    step(1);
    chk("clr_late_a", counter_a, 0);
    button = 1'b0;
    step(12);
    ca = 0;
    cb = 0;
    enable = 1'b0;
    button = 1'b1;
    step(9);
    chk("dis_a", counter_a, 0);
    chk("dis_b", counter_b, 0);
    button = 1'b0;
    step(12);
    enable = 1'b1;
    step(5);
    chk("dis_late_a", counter_a, 0);
    chk("dis_late_b", counter_b, 0);
    press(1, 0, 1, 0, 3, 0);
    press(1, 0, 2, 0, 6, 0);
    press(1, 0, 3, 0, 9, 0);
    press(1, 0, 4, 0, 10, 1);
    press(1, 0, 5, 0, 10, 1);
    reset = 1'b1;
    step(1);
    chk("rst5_a", counter_a, 0);
    chk("rst5_b", counter_b, 0);
    reset = 1'b0;
    step(2);
    $display("%0d/%0d checks passed", passed, checks);
    $finish;
  end
endmodule
